// File: rtl/ps2_host_rx.sv
// rtl/ps2_host_rx.sv - host-side PS/2 receiver with scan-code FIFO
//
// Samples ps2_clk/ps2_dat, deserializes 11-bit frames (start, 8 data LSB
// first, odd parity, stop) and buffers good bytes in a first-word-fall-through
// FIFO. Receive-only; never drives the PS/2 lines.
//
// Ports:
//   Clock, Resetn        system clock, synchronous active-low reset
//   ps2_clk, ps2_dat     asynchronous PS/2 lines
//   rd_en                pop FIFO head (ignored when empty)
//   rx_data              FIFO head byte, 0 when empty
//   rx_valid             FIFO non-empty
//   fifo_count           bytes held
//   parity_err           one-cycle pulse: odd-parity check failed
//   frame_err            one-cycle pulse: stop bit 0 or mid-frame timeout
//   overflow             one-cycle pulse: good byte dropped, FIFO full
//
// Optional feature macro: PS2_RX_BREAK_FILTER_EN
//   When defined, 0xF0 and the byte following it are not pushed, so only
//   make codes reach the FIFO.
module ps2_host_rx #(
  parameter int FIFO_AW        = 4,
  parameter int TIMEOUT_CYCLES = 60
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  input  logic               rd_en,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow
);

  localparam int         DEPTH = 1 << FIFO_AW;
  localparam logic [7:0] TMO   = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t state, state_next;

  logic clk_m, clk_s, clk_d, dat_m, dat_s;
  logic fe;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] shreg, shreg_next;
  logic par_bit, par_next;
  logic [7:0] tmo_cnt, tmo_next;
  logic byte_good, perr_next, ferr_next;
  logic push_req, push_ok, pop, full;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count_next;

  assign fe = clk_d & ~clk_s;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      clk_m      <= 1'b1;
      clk_s      <= 1'b1;
      clk_d      <= 1'b1;
      dat_m      <= 1'b1;
      dat_s      <= 1'b1;
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tmo_cnt    <= 8'h00;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_m      <= ps2_clk;
      clk_s      <= clk_m;
      clk_d      <= clk_s;
      dat_m      <= ps2_dat;
      dat_s      <= dat_m;
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      shreg      <= shreg_next;
      par_bit    <= par_next;
      tmo_cnt    <= tmo_next;
      parity_err <= perr_next;
      frame_err  <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    par_next     = par_bit;
    tmo_next     = tmo_cnt + 8'd1;
    byte_good    = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;
    if (fe || state == S_IDLE) tmo_next = 8'h00;
    case (state)
      S_IDLE: begin
        if (fe && !dat_s) begin
          state_next   = S_DATA;
          bit_cnt_next = 3'd0;
          shreg_next   = 8'h00;
        end
      end
      S_DATA: begin
        if (fe) begin
          shreg_next   = {dat_s, shreg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fe) begin
          par_next   = dat_s;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (fe) begin
          state_next = S_IDLE;
          // A bad stop bit masks the parity result.
          if (!dat_s)                     ferr_next = 1'b1;
          else if (!(^{shreg, par_bit}))  perr_next = 1'b1;
          else                            byte_good = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // An edge arriving in the same cycle restarts the count instead.
    if (state != S_IDLE && !fe && tmo_cnt == TMO) begin
      state_next = S_IDLE;
      ferr_next  = 1'b1;
      tmo_next   = 8'h00;
    end
  end

`ifdef PS2_RX_BREAK_FILTER_EN
  logic brk;

  // 0xF0 arms the filter; the next good byte (the break code) disarms it.
  always_ff @(posedge Clock) begin
    if (!Resetn)        brk <= 1'b0;
    else if (byte_good) brk <= brk ? 1'b0 : (shreg == 8'hF0);
  end

  assign push_req = byte_good && !brk && (shreg != 8'hF0);
`else
  assign push_req = byte_good;
`endif

  // fifo_count only reaches 2^FIFO_AW when full, so its MSB is the full flag.
  assign full     = fifo_count[FIFO_AW];
  assign rx_valid = |fifo_count;
  assign pop      = rd_en && rx_valid;
  assign push_ok  = push_req && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_comb begin
    count_next = fifo_count;
    case ({push_ok, pop})
      2'b10:   count_next = fifo_count + (FIFO_AW+1)'(1);
      2'b01:   count_next = fifo_count - (FIFO_AW+1)'(1);
      default: count_next = fifo_count;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow   <= push_req && full && !pop;
      fifo_count <= count_next;
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_host_rx.sv
// tb/tb_ps2_host_rx.sv - scoreboard bench for ps2_host_rx
module tb_ps2_host_rx;

  localparam int AW = 4;

  logic          Clock   = 1'b0;
  logic          Resetn  = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_dat = 1'b1;
  logic          rd_en   = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW:0]   fifo_count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  // Expected bytes in FIFO order, and expected pulse kinds (0 parity, 1 frame, 2 overflow).
  logic [7:0] exp_data[$];
  int         exp_evt[$];

  ps2_host_rx #(.FIFO_AW(AW), .TIMEOUT_CYCLES(60)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rd_en      (rd_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic evt_check(input string name, input int kind);
    if (exp_evt.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s: got pulse expected none", name);
    end else begin
      chk(name, 32'(kind), 32'(exp_evt.pop_front()));
    end
  endtask

  // Monitor: samples mid-cycle, away from the rising edge where inputs change.
  always @(negedge Clock) begin
    if (parity_err) evt_check("parity_err", 0);
    if (frame_err)  evt_check("frame_err", 1);
    if (overflow)   evt_check("overflow", 2);
    if (rd_en && rx_valid) begin
      if (exp_data.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got %0h expected no data", rx_data);
      end else begin
        chk("pop_data", 32'(rx_data), 32'(exp_data.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Keyboard model: 3 cycles high, 3 low per bit; data changes while clock is high.
  // pop_at_stop raises rd_en for exactly the cycle in which the stop edge pushes.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                            input int nbits, input bit pop_at_stop);
    logic [10:0] f;
    f = {stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (3) tick();
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
      end else begin
        repeat (3) tick();
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (4) tick();
  endtask

  task automatic good(input logic [7:0] d);
    exp_data.push_back(d);
    send_frame(d, 1'b0, 1'b1, 11, 1'b0);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_valid"},   32'(rx_valid),   32'd0);
    chk({tag, "_rx_data"},    32'(rx_data),    32'd0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    chk({tag, "_frame_err"},  32'(frame_err),  32'd0);
    chk({tag, "_overflow"},   32'(overflow),   32'd0);
  endtask

  initial begin
    repeat (4) tick();
    check_reset_outputs("reset");
    Resetn = 1'b1;
    repeat (2) tick();

    // Single good frame, then pop.
    good(8'h1C);
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_valid", 32'(rx_valid),   32'd1);
    chk("t1_data",  32'(rx_data),    32'h1C);
    pop_one();
    chk("t1_count_after_pop", 32'(fifo_count), 32'd0);
    chk("t1_data_after_pop",  32'(rx_data),    32'd0);

    // Parity error, then stop-bit error.
    exp_evt.push_back(0);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    chk("t2_perr_count", 32'(fifo_count), 32'd0);
    exp_evt.push_back(1);
    send_frame(8'h29, 1'b0, 1'b0, 11, 1'b0);
    chk("t2_ferr_count", 32'(fifo_count), 32'd0);

    // Start + 4 data bits, then line idle long enough to time out.
    exp_evt.push_back(1);
    send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0);
    repeat (70) tick();
    chk("t3_tmo_count", 32'(fifo_count), 32'd0);
    good(8'h29);
    chk("t3_data", 32'(rx_data), 32'h29);
    pop_one();

    // Overflow on the 17th frame.
    for (int i = 1; i <= 16; i++) good(8'(i));
    exp_evt.push_back(2);
    send_frame(8'h11, 1'b0, 1'b1, 11, 1'b0);
    chk("t4_count", 32'(fifo_count), 32'd16);
    chk("t4_head",  32'(rx_data),    32'h01);
    repeat (16) pop_one();
    chk("t4_drained", 32'(fifo_count), 32'd0);

    // Full FIFO with a pop in the push cycle: push accepted, no overflow.
    for (int i = 8'h20; i <= 8'h2F; i++) good(8'(i));
    exp_data.push_back(8'h30);
    send_frame(8'h30, 1'b0, 1'b1, 11, 1'b1);
    chk("t5_count", 32'(fifo_count), 32'd16);
    chk("t5_head",  32'(rx_data),    32'h21);
    repeat (16) pop_one();
    chk("t5_drained", 32'(fifo_count), 32'd0);

    // Make/break sequence.
`ifdef PS2_RX_BREAK_FILTER_EN
    good(8'h1C);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("t6_count", 32'(fifo_count), 32'd1);
`else
    good(8'h1C);
    good(8'hF0);
    good(8'h1C);
    chk("t6_count", 32'(fifo_count), 32'd3);
`endif
    while (exp_data.size() != 0) pop_one();
    chk("t6_drained", 32'(fifo_count), 32'd0);

    // Reset in the middle of a frame with a byte already buffered.
    good(8'h5A);
    send_frame(8'h33, 1'b0, 1'b1, 6, 1'b0);
    Resetn = 1'b0;
    exp_data.delete();
    repeat (3) tick();
    check_reset_outputs("midreset");
    Resetn = 1'b1;
    repeat (2) tick();
    good(8'h6B);
    chk("t7_count", 32'(fifo_count), 32'd1);
    chk("t7_data",  32'(rx_data),    32'h6B);
    pop_one();

    repeat (5) tick();
    chk("pending_events", 32'(exp_evt.size()),  32'd0);
    chk("pending_data",   32'(exp_data.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_rx.md
# ps2_host_rx

Host-side PS/2 receiver: samples the `ps2_clk`/`ps2_dat` lines driven by a PS/2 keyboard, deserializes 11-bit frames, and checks parity and stop bits. Valid scan-code bytes are buffered in a first-word-fall-through FIFO for a consumer such as a keyboard-decode FSM or display logic. Sits between the PS/2 pins (or the keyboard model in testbenches) and user logic. The block is receive-only and never drives the PS/2 lines.

## Interface
Parameters:
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW.
- `TIMEOUT_CYCLES`, 60: Clock cycles without a ps2_clk falling edge, mid-frame, before the frame is aborted. Range 8..255.

Ports:
- `Clock`  in  1  system clock.
- `Resetn`  in  1  reset: synchronous, active-low; clock Clock.
- `ps2_clk`  in  1  PS/2 clock line, asynchronous.
- `ps2_dat`  in  1  PS/2 data line, asynchronous.
- `rd_en`  in  1  pop FIFO head; ignored when `rx_valid`=0.
- `rx_data`  out  8  FIFO head byte; 0 when empty.
- `rx_valid`  out  1  FIFO non-empty.
- `fifo_count`  out  FIFO_AW+1  bytes held.
- `parity_err`  out  1  one-cycle pulse: frame failed odd-parity check.
- `frame_err`  out  1  one-cycle pulse: stop bit 0, or timeout.
- `overflow`  out  1  one-cycle pulse: good byte dropped because FIFO full.

## Operation
- Synchronization: two-flop synchronizers on both lines, giving `clk_s` and `dat_s`. A third flop `clk_d` delays `clk_s`. Falling edge `fe` = `clk_d` & ~`clk_s`. Data is sampled as `dat_s` when `fe` is true.
- Frame format, LSB first: START(0), d0..d7, PARITY (odd over d0..d7 plus parity), STOP(1).
- FSM states:
  - IDLE: on `fe` with `dat_s`=0, go to DATA and clear the bit counter. On `fe` with `dat_s`=1, stay in IDLE; the edge is ignored.
  - DATA: on each `fe`, shift `dat_s` into bit[7] of an 8-bit shift register (right shift). After the 8th bit, go to PARITY.
  - PARITY: on `fe`, store the parity bit and go to STOP.
  - STOP: on `fe`, return to IDLE.
    - Stop bit 0: pulse `frame_err` only; nothing is pushed. This takes priority over the parity check.
    - Stop bit 1 with bad parity: pulse `parity_err`; nothing is pushed.
    - Stop bit 1 with good parity: push the byte.
- Timeout: an 8-bit counter clears on every `fe` and in IDLE, and increments otherwise. In DATA, PARITY or STOP, when the counter reaches TIMEOUT_CYCLES: go to IDLE, pulse `frame_err`, discard partial bits.
- FIFO: circular buffer with read and write pointers plus `fifo_count`. `rx_data` is combinational from the head entry.
  - Push and pop in the same cycle: both occur, and `fifo_count` is unchanged. This includes the full case, where the push is accepted because a slot frees.
  - Push when full with no pop: byte dropped, `overflow` pulses, FIFO contents unchanged.
  - Pop when empty: no effect.
- Pointers wrap modulo 2^FIFO_AW.

## Timing
- Reset values: FSM IDLE, synchronizer flops 1, `fifo_count`=0, pointers 0, `rx_valid`=0, `rx_data`=0, all error and overflow pulses 0. The timeout counter is 0 and the shift register is 0.
- Reset asserted mid-frame: the partial frame is lost. A following frame is received normally once its start bit arrives.
- Latency: let t0 be the first rising Clock edge that samples the pin `ps2_clk` low.
  - `clk_s` falls at t0+1, so `fe` is true during the cycle t0+1..t0+2.
  - The FSM and FIFO act at t0+2.
  - For a stop-bit edge, `rx_valid` and `fifo_count` update after t0+2.
  - Error and overflow pulses are high for exactly the cycle following t0+2.
- Input constraint: each ps2_clk high and low phase must last at least 3 Clock cycles. The keyboard model uses 6 Clock cycles per ps2_clk period.
- Pop: after the rising edge with `rd_en`=1, `rx_data` shows the next entry.

## Configuration
- `PS2_RX_BREAK_FILTER_EN`:
  - Defined: a received 0xF0 is not pushed and sets a `brk` flag. The next good byte is also discarded and clears `brk`. A frame error or parity error while `brk` is set leaves `brk` set. Reset clears `brk`. Overflow cannot occur for discarded bytes. Result: only make codes reach the FIFO.
  - Undefined: every good byte, including 0xF0, is pushed; no `brk` flag exists.

## Test plan
- Frame 0x1C with parity 0, stop 1 -> `rx_valid`=1, `rx_data`=0x1C, `fifo_count`=1, no error pulses. Then `rd_en` for 1 cycle -> `fifo_count`=0, `rx_data`=0.
- Frame 0x1C with parity 1 -> single `parity_err` pulse, `fifo_count`=0. Frame 0x29 with stop bit 0 -> single `frame_err` pulse, no push.
- Send start bit and 4 data bits, then hold ps2_clk high for 70 cycles -> `frame_err` pulses once, FSM back in IDLE. A following 0x29 frame -> `rx_data`=0x29.
- 17 good frames 0x01..0x11 with no reads -> `fifo_count`=16, `overflow` pulses on frame 17, `rx_data`=0x01. Then pop 16 times -> bytes 0x01..0x10 in order.
- FIFO full, with `rd_en` asserted in the push cycle -> `fifo_count` stays 16, no `overflow`, last entry = new byte.
- Sequence 0x1C, 0xF0, 0x1C -> with `PS2_RX_BREAK_FILTER_EN`: `fifo_count`=1 (0x1C). Without: `fifo_count`=3 (0x1C, 0xF0, 0x1C). Additionally, `Resetn` low during bit 5 of a frame -> all outputs at reset values.
